// File: rtl/hamming_motion_detector_pkg.sv
// hamming_motion_detector_pkg: shared state encoding, opcodes and signature geometry.
package hamming_motion_detector_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, REPORT} state_t;
  localparam logic [1:0] OP_DIST = 2'd0;
  localparam logic [1:0] OP_STATUS = 2'd1;
  localparam logic [1:0] OP_THRESH = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;
  localparam int WORDS = 4;
endpackage

// File: rtl/popcount32.sv
// popcount32: combinational population count of a 32-bit word.
module popcount32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 32; i++) o_count = o_count + {5'd0, i_data[i]};
  end
endmodule

// File: rtl/hamming_motion_detector.sv
// hamming_motion_detector: Hamming distance between consecutive 128-bit frame signatures,
// thresholded into motion flags, with a custom-instruction control/status port.
module hamming_motion_detector
  import hamming_motion_detector_pkg::*;
#(
  parameter logic [7:0] customId = 8'd1,
  parameter logic [7:0] defaultThreshold = 8'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frameStart,
  input  logic        sigValid,
  input  logic [31:0] sigData,
  output logic        sigReady,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic [7:0]  distance,
  output logic        motionFlag,
  output logic        motionEvent
);
  state_t      r_state;
  logic [1:0]  r_idx;
  logic [8:0]  r_acc;
  logic [31:0] r_prev [WORDS];
  logic [31:0] r_stage [WORDS];
  logic [7:0]  r_thr;
  logic [15:0] r_cnt;
  logic        r_first;
  logic        r_sticky;
  logic        w_accept;
  logic        w_ci;
  logic        w_motion;
  logic [1:0]  w_idx;
  logic [1:0]  w_op;
  logic [5:0]  w_pop;
  logic        w_unused;

  assign sigReady = r_state == IDLE || r_state == ACCUM;
  assign w_accept = sigValid && sigReady;
  // a word arriving with frameStart is word 0 of the new frame
  assign w_idx = frameStart ? 2'd0 : r_idx;
  assign w_ci = ciStart && ciN == customId;
  assign w_op = ciValueA[1:0];
  assign w_motion = r_state == REPORT && r_first && r_acc > {1'b0, r_thr};
  assign w_unused = ^{ciValueA[31:2], ciValueB[31:8]};

  popcount32 u_popcount (
    .i_data (sigData ^ r_prev[w_idx]),
    .o_count(w_pop)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_acc <= '0;
      distance <= '0;
      r_cnt <= '0;
      motionFlag <= 1'b0;
      motionEvent <= 1'b0;
      r_sticky <= 1'b0;
      r_first <= 1'b0;
      ciDone <= 1'b0;
      ciResult <= '0;
      r_thr <= defaultThreshold;
    end else begin
      r_state <= frameStart ? (w_accept ? ACCUM : IDLE) :
                 r_state == IDLE ? (w_accept ? ACCUM : IDLE) :
                 r_state == ACCUM ? (w_accept && r_idx == 2'd3 ? COMPARE : ACCUM) :
                 r_state == COMPARE ? REPORT : IDLE;
      if (w_accept) begin
        r_idx <= w_idx + 2'd1;
        r_acc <= (w_idx == 2'd0 ? 9'd0 : r_acc) + {3'd0, w_pop};
      end else if (frameStart) begin
        r_idx <= '0;
        r_acc <= '0;
      end
      if (r_state == REPORT) begin
        distance <= r_first ? r_acc[7:0] : 8'd0;
        motionFlag <= w_motion;
        r_cnt <= r_cnt + 16'd1;
        r_first <= 1'b1;
      end
      motionEvent <= w_motion;
      r_sticky <= w_motion || (r_sticky && !(w_ci && w_op == OP_CLEAR));
      if (w_ci && w_op == OP_THRESH) r_thr <= ciValueB[7:0];
      ciDone <= w_ci;
      ciResult <= !w_ci ? 32'd0 :
                  w_op == OP_DIST ? {24'd0, distance} :
                  w_op == OP_STATUS ? {13'd0, r_sticky, motionFlag, r_first, r_cnt} : 32'd0;
    end
  end

  // signature storage is masked by r_first, so it carries no reset
  always_ff @(posedge clock) begin
    if (w_accept) r_stage[w_idx] <= sigData;
    if (r_state == REPORT) r_prev <= r_stage;
  end
endmodule

// File: tb/tb_hamming_motion_detector.sv
// tb_hamming_motion_detector: directed table, corner-case sequences and random frames
// checked against a whole-signature reference model.
module tb_hamming_motion_detector;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frameStart = 1'b0;
  logic        sigValid = 1'b0;
  logic [31:0] sigData = '0;
  logic        sigReady;
  logic        ciStart = 1'b0;
  logic [7:0]  ciN = '0;
  logic [31:0] ciValueA = '0;
  logic [31:0] ciValueB = '0;
  logic [31:0] ciResult;
  logic        ciDone;
  logic [7:0]  distance;
  logic        motionFlag;
  logic        motionEvent;

  int n_checks = 0;
  int n_fail = 0;

  logic [127:0] m_prev;
  bit           m_have;
  int           m_thr;
  logic [15:0]  m_cnt;
  bit           m_sticky;
  bit           m_flag;
  int           m_dist;

  typedef struct {
    logic [127:0] sig;
    int           thr;
    int           exp_dist;
    bit           exp_flag;
  } vec_t;
  vec_t tbl [5];

  always #5 clock = ~clock;

  hamming_motion_detector #(.customId(8'd1), .defaultThreshold(8'd16)) dut (
    .clock(clock), .reset(reset), .frameStart(frameStart), .sigValid(sigValid),
    .sigData(sigData), .sigReady(sigReady), .ciStart(ciStart), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB), .ciResult(ciResult), .ciDone(ciDone),
    .distance(distance), .motionFlag(motionFlag), .motionEvent(motionEvent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    m_have = 0;
    m_thr = 16;
    m_cnt = '0;
    m_sticky = 0;
    m_flag = 0;
    m_dist = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit fs);
    sigValid = 1'b1;
    sigData = d;
    frameStart = fs;
    tick;
    sigValid = 1'b0;
    frameStart = 1'b0;
  endtask

  function automatic void model_frame(input logic [127:0] sig);
    m_dist = m_have ? $countones(sig ^ m_prev) : 0;
    m_flag = m_have && m_dist > m_thr;
    m_sticky = m_sticky || m_flag;
    m_cnt = m_cnt + 16'd1;
    m_prev = sig;
    m_have = 1;
  endfunction

  task automatic check_outputs(input string name);
    chk({name, " distance"}, {24'd0, distance}, m_dist);
    chk({name, " motionFlag"}, {31'd0, motionFlag}, {31'd0, m_flag});
    chk({name, " motionEvent"}, {31'd0, motionEvent}, {31'd0, m_flag});
  endtask

  task automatic ci(input logic [7:0] id, input logic [1:0] op, input logic [31:0] b, input string name);
    bit hit;
    logic [31:0] exp;
    hit = id == 8'd1;
    exp = '0;
    if (hit && op == 2'd0) exp = {24'd0, 8'(m_dist)};
    if (hit && op == 2'd1) exp = {13'd0, m_sticky, m_flag, m_have, m_cnt};
    ciStart = 1'b1;
    ciN = id;
    ciValueA = ($urandom() & 32'hFFFF_FFFC) | {30'd0, op};
    ciValueB = b;
    tick;
    ciStart = 1'b0;
    chk({name, " ciDone"}, {31'd0, ciDone}, {31'd0, hit});
    chk({name, " ciResult"}, ciResult, exp);
    if (hit && op == 2'd2) m_thr = int'(b[7:0]);
    if (hit && op == 2'd3) m_sticky = 0;
    tick;
    chk({name, " ciDone idle"}, {31'd0, ciDone}, 32'd0);
    chk({name, " ciResult idle"}, ciResult, 32'd0);
  endtask

  // thr_rep >= 0 writes that threshold during the REPORT cycle of this frame
  task automatic send_frame(input logic [127:0] sig, input int gap_max, input bit fs0,
                            input int thr_rep, input string name);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick;
      send_word(sig[i*32 +: 32], fs0 && i == 0);
    end
    chk({name, " ready compare"}, {31'd0, sigReady}, 32'd0);
    tick;
    chk({name, " ready report"}, {31'd0, sigReady}, 32'd0);
    chk({name, " early event"}, {31'd0, motionEvent}, 32'd0);
    if (thr_rep >= 0) begin
      ciStart = 1'b1;
      ciN = 8'd1;
      ciValueA = 32'd2;
      ciValueB = thr_rep;
    end
    tick;
    ciStart = 1'b0;
    model_frame(sig);
    check_outputs(name);
    if (thr_rep >= 0) begin
      chk({name, " thr ciDone"}, {31'd0, ciDone}, 32'd1);
      m_thr = thr_rep;
    end
    tick;
    chk({name, " event pulse end"}, {31'd0, motionEvent}, 32'd0);
  endtask

  function automatic logic [127:0] near(input int k);
    logic [127:0] mask;
    mask = '0;
    repeat (k) mask[$urandom_range(127, 0)] = 1'b1;
    return m_have ? m_prev ^ mask : {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] s1;
    logic [127:0] s2;
    tbl[0] = '{128'h0, 16, 0, 1'b0};
    tbl[1] = '{{4{32'h0000_001F}}, 16, 20, 1'b1};
    tbl[2] = '{128'h0, 20, 20, 1'b0};
    tbl[3] = '{{32'h3F, 32'h1F, 32'h1F, 32'h1F}, 20, 21, 1'b1};
    tbl[4] = '{{32'h3F, 32'h1F, 32'h1F, 32'h1F}, 20, 0, 1'b0};
    do_reset;
    chk("reset distance", {24'd0, distance}, 32'd0);
    chk("reset motionFlag", {31'd0, motionFlag}, 32'd0);
    chk("reset motionEvent", {31'd0, motionEvent}, 32'd0);
    chk("reset ciDone", {31'd0, ciDone}, 32'd0);
    chk("reset ciResult", ciResult, 32'd0);
    chk("reset sigReady", {31'd0, sigReady}, 32'd1);
    ci(8'd1, 2'd1, 0, "reset status");

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].thr != m_thr) ci(8'd1, 2'd2, tbl[i].thr, "set thr");
      send_frame(tbl[i].sig, 2, 1'b0, -1, "table");
      chk("table exp distance", {24'd0, distance}, tbl[i].exp_dist);
      chk("table exp flag", {31'd0, motionFlag}, {31'd0, tbl[i].exp_flag});
      ci(8'd1, 2'd1, 0, "table status");
    end

    ci(8'd2, 2'd1, 0, "wrong id");
    ci(8'd1, 2'd3, 0, "clear sticky");
    ci(8'd1, 2'd1, 0, "status after clear");
    ci(8'd1, 2'd0, 0, "read distance");

    send_frame(m_prev ^ 128'h1F, 1, 1'b0, 0, "thr in report");
    send_frame(m_prev ^ 128'h1F, 1, 1'b0, -1, "thr next frame");

    send_word(~m_prev[31:0], 1'b0);
    send_word(~m_prev[63:32], 1'b0);
    frameStart = 1'b1;
    tick;
    frameStart = 1'b0;
    send_frame(m_prev, 1, 1'b0, -1, "after partial");
    repeat (3) send_word($urandom(), 1'b0);
    send_frame(m_prev, 1, 1'b1, -1, "partial fs with word");

    s1 = near(12);
    s2 = s1 ^ {4{32'h8000_0001}};
    sigValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sigData = s1[i*32 +: 32];
      tick;
    end
    chk("held ready compare", {31'd0, sigReady}, 32'd0);
    sigData = $urandom();
    tick;
    chk("held ready report", {31'd0, sigReady}, 32'd0);
    sigData = $urandom();
    tick;
    model_frame(s1);
    check_outputs("held frame");
    chk("held ready idle", {31'd0, sigReady}, 32'd1);
    send_frame(s2, 0, 1'b0, -1, "held next");

    send_word($urandom(), 1'b0);
    send_word($urandom(), 1'b0);
    do_reset;
    ci(8'd1, 2'd1, 0, "mid reset status");
    send_frame(near(0), 1, 1'b0, -1, "first after reset");

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(5, 0))
        0: ci(8'd1, 2'd0, 0, "rand dist");
        1: ci(8'd1, 2'd1, 0, "rand status");
        2: ci(8'd1, 2'd2, $urandom_range(30, 8), "rand thr");
        3: ci(8'd1, 2'd3, 0, "rand clear");
        4: ci(8'($urandom_range(255, 2)), 2'($urandom_range(3, 0)), $urandom(), "rand other id");
        default: ;
      endcase
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) send_word($urandom(), 1'b0);
        if ($urandom_range(1, 0) == 1) begin
          frameStart = 1'b1;
          tick;
          frameStart = 1'b0;
          send_frame(near($urandom_range(40, 0)), 2, 1'b0, -1, "rand partial");
        end else send_frame(near($urandom_range(40, 0)), 2, 1'b1, -1, "rand fs word");
      end else begin
        send_frame(near($urandom_range(40, 0)), 2, 1'b0,
                   $urandom_range(4, 0) == 0 ? int'($urandom_range(30, 8)) : -1, "rand frame");
      end
    end
    ci(8'd1, 2'd1, 0, "final status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
